fc_data_reader: RTL and testbench

Sequencer that sits directly downstream of the FC data buffer and streams its contents to the fully-connected MAC array. On `start` it reads input-vector addresses 0..`in_len`-1 from the buffer's read port, once per output-neuron pass, for `out_len` passes. It absorbs the buffer's 1-cycle read latency and downstream backpressure with a 2-entry skid FIFO, and signals completion with a `done` pulse.

---
 rtl/fc_data_reader.sv | 116 +++++++++++
 tb/tb_fc_data_reader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fc_data_reader.sv
// fc_data_reader: streams FC buffer words 0..in_len-1 once per pass for out_len passes,
// hiding the buffer's 1-cycle read latency behind a 2-entry skid FIFO.
module fc_data_reader #(
    parameter int SRAM_DEPTH = 1024,
    parameter int DATA_WIDTH = 8,
    parameter int PASS_WIDTH = 10,
    localparam int AW = $clog2(SRAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [AW:0]           in_len,
    input  logic [PASS_WIDTH-1:0] out_len,
    output logic                  enb,
    output logic [AW-1:0]         addrb,
    input  logic [DATA_WIDTH-1:0] dob,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic                  o_last,
    output logic                  o_final,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                state, state_nxt;
    logic [AW:0]           len_in;
    logic [PASS_WIDTH-1:0] len_out;
    logic [AW-1:0]         elem;
    logic [PASS_WIDTH-1:0] pass;
    logic                  rd_v, rd_last, rd_final;
    logic [DATA_WIDTH+1:0] mem [2];
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            fcnt, cnt;
    logic                  pop, is_last, is_final, go;

    assign go       = (in_len != '0) && (out_len != '0);
    assign is_last  = {1'b0, elem} == len_in - 1'b1;
    assign is_final = is_last && (pass == len_out - 1'b1);
    assign o_valid  = fcnt != 2'd0;
    assign pop      = o_valid & o_ready;
    // credits cover FIFO entries plus the read still in flight from the buffer
    assign cnt      = fcnt + {1'b0, rd_v};
    assign addrb    = elem;
    assign o_data   = mem[rd_ptr][DATA_WIDTH+1:2];
    assign o_last   = mem[rd_ptr][1];
    assign o_final  = mem[rd_ptr][0];

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        enb       = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  state_nxt = start ? (go ? FETCH : DONE) : IDLE;
            FETCH: begin
                busy      = 1'b1;
                enb       = (cnt < 2'd2) || pop;
                state_nxt = (enb && is_final) ? DRAIN : FETCH;
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = (cnt == {1'b0, pop}) ? DONE : DRAIN;
            end
            default: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            len_in   <= '0;
            len_out  <= '0;
            elem     <= '0;
            pass     <= '0;
            rd_v     <= 1'b0;
            rd_last  <= 1'b0;
            rd_final <= 1'b0;
        end else begin
            if (state == IDLE && start && go) begin
                len_in  <= in_len;
                len_out <= out_len;
                elem    <= '0;
                pass    <= '0;
            end else if (enb) begin
                elem <= is_last ? '0 : elem + 1'b1;
                pass <= is_last ? pass + 1'b1 : pass;
            end
            rd_v     <= enb;
            rd_last  <= enb && is_last;
            rd_final <= enb && is_final;
        end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            fcnt   <= 2'd0;
        end else begin
            if (rd_v) begin
                mem[wr_ptr] <= {dob, rd_last, rd_final};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fcnt <= fcnt + {1'b0, rd_v} - {1'b0, pop};
        end
endmodule

// File: tb/tb_fc_data_reader.sv
// tb_fc_data_reader: random and directed jobs against a queue-based stream model
// with a decoupled monitor comparing addresses, data and flags.
module tb_fc_data_reader;
    localparam int DEPTH = 1024;
    localparam int DW = 8;
    localparam int PW = 10;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   in_len = '0;
    logic [PW-1:0] out_len = '0;
    logic          enb;
    logic [AW-1:0] addrb;
    logic [DW-1:0] dob;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_ready = 1'b1;
    logic          o_last, o_final, busy, done;

    typedef struct packed {logic [DW-1:0] d; logic l; logic f;} elem_t;
    elem_t         exp_q[$];
    int            addr_q[$];
    logic [DW-1:0] sram [DEPTH];
    int            errors = 0;
    int            checks = 0;
    int            rdy_mode = 1;
    logic          stall_p = 1'b0;
    elem_t         held;

    fc_data_reader #(.SRAM_DEPTH(DEPTH), .DATA_WIDTH(DW), .PASS_WIDTH(PW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .in_len(in_len), .out_len(out_len),
        .enb(enb), .addrb(addrb), .dob(dob), .o_data(o_data), .o_valid(o_valid),
        .o_ready(o_ready), .o_last(o_last), .o_final(o_final), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (enb) dob <= sram[addrb];

    initial forever begin
        @(posedge clk);
        #1;
        o_ready = rdy_mode == 2 ? 1'($urandom_range(0, 1)) : rdy_mode == 1;
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rstn) stall_p = 1'b0;
        else begin
            if (stall_p) begin
                chk("stall_valid", 32'(o_valid), 32'd1);
                chk("stall_head", 32'({o_data, o_last, o_final}), 32'(held));
            end
            if (enb) begin
                if (addr_q.size() == 0) chk("extra_read", 32'(addrb), 32'hffff);
                else chk("addrb", 32'(addrb), 32'(addr_q.pop_front()));
            end
            if (o_valid && o_ready) begin
                if (exp_q.size() == 0) chk("extra_elem", 32'(o_data), 32'hffff);
                else chk("elem", 32'({o_data, o_last, o_final}), 32'(exp_q.pop_front()));
            end
            stall_p = o_valid && !o_ready;
            held = {o_data, o_last, o_final};
        end
    end

    task automatic run_job(input int il, input int ol, input int mode, input bit mid);
        int c = 0;
        int fe = -1;
        int fv = -1;
        int dc = -1;
        int ne = 0;
        for (int p = 0; p < ol; p++)
            for (int i = 0; i < il; i++) begin
                addr_q.push_back(i);
                exp_q.push_back({sram[i], i == il - 1, (i == il - 1) && (p == ol - 1)});
            end
        rdy_mode = mode;
        @(posedge clk);
        #1;
        start = 1'b1;
        in_len = 11'(il);
        out_len = 10'(ol);
        @(posedge clk);
        #1;
        start = 1'b0;
        in_len = 11'($urandom);
        out_len = 10'($urandom);
        while (dc < 0 && c < 20000) begin
            @(negedge clk);
            c++;
            if (c == 1) chk("busy_c1", 32'(busy), 32'(il > 0 && ol > 0));
            if (mid && c == 5) start = 1'b1;
            if (mid && c == 6) start = 1'b0;
            if (enb) begin
                ne++;
                if (fe < 0) fe = c;
            end
            if (o_valid && fv < 0) fv = c;
            if (done) begin
                dc = c;
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
        if (dc < 0) chk("done_timeout", 32'd0, 32'd1);
        chk("enb_count", 32'(ne), 32'(il * ol));
        chk("elems_left", 32'(exp_q.size()), 32'd0);
        chk("addrs_left", 32'(addr_q.size()), 32'd0);
        if (il > 0 && ol > 0) begin
            if (mode == 1) begin
                chk("first_enb_cycle", 32'(fe), 32'd1);
                chk("first_valid_cycle", 32'(fv), 32'd3);
                chk("done_cycle", 32'(dc), 32'(il * ol + 3));
            end
        end else chk("zero_done_cycle", 32'(dc), 32'd1);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) sram[i] = 8'(i + 1);
        repeat (2) @(negedge clk);
        chk("rst_outs", 32'({enb, addrb, o_data, o_valid, o_last, o_final, busy, done}), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        run_job(4, 1, 1, 1'b0);
        run_job(3, 2, 1, 1'b1);
        for (int i = 0; i < DEPTH; i++) sram[i] = 8'($urandom);
        run_job(16, 3, 2, 1'b0);
        run_job(0, 5, 1, 1'b0);
        run_job(7, 0, 2, 1'b0);
        for (int i = 0; i < 48; i++) begin
            addr_q.push_back(i % 16);
            exp_q.push_back('0);
        end
        rdy_mode = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        in_len = 11'd16;
        out_len = 10'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_fifo_full", 32'(o_valid), 32'd1);
        #1;
        rstn = 1'b0;
        #1;
        chk("abort_outs", 32'({enb, addrb, o_data, o_valid, o_last, o_final, busy, done}), 32'd0);
        addr_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        run_job(5, 2, 1, 1'b0);
        for (int k = 0; k < 6; k++)
            run_job(int'($urandom_range(1, 24)), int'($urandom_range(1, 4)), int'($urandom_range(1, 2)), 1'b0);
        run_job(DEPTH, 2, 1, 1'b0);
        run_job(1, 1, 1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
